// File: rtl/pipe_valid_sequencer_if.sv
// Handshake bundle between the layer controller (master) and the PE-column
// sequencer (slave): command inputs, issue-side tags and shadowed output tags.
interface pipe_valid_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             START;
   logic [CNT_W-1:0] NUM_BEATS;
   logic             HOLD;
   logic             ISSUE_VALID;
   logic             ISSUE_LAST;
   logic             OUT_VALID;
   logic             OUT_LAST;
   logic             BUSY;
   logic             DONE;
   logic [CNT_W-1:0] BEATS_LEFT;

   modport master (
      output START, NUM_BEATS, HOLD,
      input  ISSUE_VALID, ISSUE_LAST, OUT_VALID, OUT_LAST, BUSY, DONE, BEATS_LEFT
   );

   modport slave (
      input  START, NUM_BEATS, HOLD,
      output ISSUE_VALID, ISSUE_LAST, OUT_VALID, OUT_LAST, BUSY, DONE, BEATS_LEFT
   );
endinterface

// File: rtl/pipe_valid_sequencer.sv
// Issues a counted burst of beats into a fixed-latency, non-stallable PE
// datapath and tracks valid/last through a matching shadow pipeline.
module pipe_valid_sequencer #(
   parameter int LATENCY = 3,
   parameter int CNT_W   = 16
) (
   input logic                     CLK,
   input logic                     RESET,
   pipe_valid_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_nextCount;
   logic             w_issueValid;
   logic             w_issueLast;
   logic             w_outValid;
   logic             w_outLast;
   logic [1:0]       r_shadow [LATENCY];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
      end
   end

   // The counter only decrements on an actual issue, so it reaches zero exactly
   // as ISSUE is left and can never wrap, even for an all-ones beat count.
   always_comb begin
      w_nextState  = r_state;
      w_nextCount  = r_count;
      w_issueValid = 1'b0;
      w_issueLast  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.START) begin
               if (bus.NUM_BEATS != '0) begin
                  w_nextState = S_ISSUE;
                  w_nextCount = bus.NUM_BEATS;
               end else begin
                  w_nextState = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            if (!bus.HOLD) begin
               w_issueValid = 1'b1;
               w_issueLast  = (r_count == ONE);
               w_nextCount  = r_count - ONE;
               if (r_count == ONE) begin
                  w_nextState = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (w_outValid && w_outLast) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   // Stage k mirrors datapath register k; reset flushes it so no stale beat
   // can surface after an abandoned command.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < LATENCY; k++) begin
            r_shadow[k] <= 2'b00;
         end
      end else begin
         r_shadow[0] <= {w_issueValid, w_issueLast};
         for (int k = 1; k < LATENCY; k++) begin
            r_shadow[k] <= r_shadow[k-1];
         end
      end
   end

   assign w_outValid = r_shadow[LATENCY-1][1];
   assign w_outLast  = r_shadow[LATENCY-1][0];

   assign bus.ISSUE_VALID = w_issueValid;
   assign bus.ISSUE_LAST  = w_issueLast;
   assign bus.OUT_VALID   = w_outValid;
   assign bus.OUT_LAST    = w_outLast;
   assign bus.BUSY        = (r_state != S_IDLE);
   assign bus.DONE        = (r_state == S_DONE);
   assign bus.BEATS_LEFT  = r_count;

endmodule

// File: tb/tb_pipe_valid_sequencer.sv
// Randomized scoreboard bench for pipe_valid_sequencer: expected issue/status
// per cycle and expected output beats are derived from command timestamps.
module tb_pipe_valid_sequencer;

   localparam int LAT = 3;
   localparam int CW  = 8;

   typedef struct {
      int          cyc;
      logic        iv;
      logic        il;
      logic [CW-1:0] left;
      logic        busy;
      logic        done;
   } ctl_t;

   typedef struct {
      int   cyc;
      logic last;
   } out_t;

   logic CLK = 1'b0;
   logic RESET;
   int   cyc = 0;
   bit   checking = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;
   ctl_t ctlQ[$];
   out_t outQ[$];

   always #5 CLK = ~CLK;

   pipe_valid_sequencer_if #(.CNT_W(CW)) bus ();

   pipe_valid_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   task automatic nextCycle();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic pushCtl(input bit iv, input bit il, input int left, input bit busy, input bit done);
      ctl_t e;
      e.cyc  = cyc;
      e.iv   = iv;
      e.il   = il;
      e.left = CW'(left);
      e.busy = busy;
      e.done = done;
      ctlQ.push_back(e);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.START     = 1'b0;
         bus.NUM_BEATS = CW'($urandom);
         bus.HOLD      = 1'($urandom);
         pushCtl(0, 0, 0, 0, 0);
         nextCycle();
      end
   endtask

   // A command accepted in cycle s issues its beats on the first n HOLD-free
   // cycles after s; each beat leaves LAT cycles later and DONE follows the last.
   task automatic applyStimulus(input int n, input logic [63:0] holdMask, input int abortAt, input bit startHeld);
      int k;
      int off;
      int d;
      k   = 0;
      off = 0;
      d   = (n == 0) ? cyc + 1 : -1;
      bus.START     = 1'b1;
      bus.NUM_BEATS = CW'(n);
      bus.HOLD      = 1'($urandom);
      pushCtl(0, 0, 0, 0, 0);
      forever begin
         nextCycle();
         off++;
         bus.START     = startHeld ? 1'b1 : 1'($urandom);
         bus.NUM_BEATS = CW'($urandom);
         if (k < n) begin
            bus.HOLD = (off <= 64) ? holdMask[off-1] : 1'b0;
            if (!bus.HOLD) begin
               pushCtl(1, (k == n - 1), n - k, 1, 0);
               outQ.push_back('{cyc: cyc + LAT, last: (k == n - 1)});
               k++;
               if (k == n) d = cyc + LAT + 1;
            end else begin
               pushCtl(0, 0, n - k, 1, 0);
            end
         end else begin
            bus.HOLD = 1'($urandom);
            pushCtl(0, 0, 0, 1, (cyc == d));
         end
         if (off == abortAt) begin
            RESET = 1'b1;
            nextCycle();
            RESET = 1'b0;
            outQ.delete();
            return;
         end
         if (cyc == d || off > 2000) break;
      end
      nextCycle();
   endtask

   // Monitor: status is compared every cycle that has an expectation, output
   // beats are popped from the scoreboard when their cycle comes up.
   always @(negedge CLK) begin : checkOutput
      ctl_t e;
      out_t o;
      logic expV;
      logic expL;
      if (checking) begin
         if (ctlQ.size() > 0 && ctlQ[0].cyc == cyc) begin
            e = ctlQ.pop_front();
            testsRun++;
            if ({bus.ISSUE_VALID, bus.ISSUE_LAST, bus.BEATS_LEFT, bus.BUSY, bus.DONE} !==
                {e.iv, e.il, e.left, e.busy, e.done}) begin
               testsFailed++;
               $display("[TB] FAIL status cycle %0d: got iv=%b il=%b left=%0d busy=%b done=%b, expected iv=%b il=%b left=%0d busy=%b done=%b",
                        cyc, bus.ISSUE_VALID, bus.ISSUE_LAST, bus.BEATS_LEFT, bus.BUSY, bus.DONE,
                        e.iv, e.il, e.left, e.busy, e.done);
            end
         end
         expV = 1'b0;
         expL = 1'b0;
         if (outQ.size() > 0 && outQ[0].cyc == cyc) begin
            o    = outQ.pop_front();
            expV = 1'b1;
            expL = o.last;
         end
         testsRun++;
         if ({bus.OUT_VALID, bus.OUT_LAST} !== {expV, expL}) begin
            testsFailed++;
            $display("[TB] FAIL out cycle %0d: got valid=%b last=%b, expected valid=%b last=%b",
                     cyc, bus.OUT_VALID, bus.OUT_LAST, expV, expL);
         end
      end
   end

   initial begin
      int n;
      int ab;
      logic [63:0] mask;
      RESET         = 1'b1;
      bus.START     = 1'b0;
      bus.NUM_BEATS = '0;
      bus.HOLD      = 1'b0;
      nextCycle();
      nextCycle();
      RESET    = 1'b0;
      checking = 1'b1;

      idleCycles(2);
      applyStimulus(4, 64'h0, 0, 1'b0);
      applyStimulus(4, 64'h6, 0, 1'b0);
      applyStimulus(0, 64'h0, 0, 1'b0);
      idleCycles(1);
      applyStimulus(2, 64'h0, 0, 1'b1);
      applyStimulus(2, 64'h0, 0, 1'b1);
      idleCycles(1);
      applyStimulus(4, 64'h0, 3, 1'b0);
      applyStimulus(4, 64'h0, 0, 1'b0);
      applyStimulus((1 << CW) - 1, 64'h0, 0, 1'b0);
      applyStimulus(1, 64'h0, 0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         idleCycles($urandom_range(0, 2));
         n    = $urandom_range(0, 12);
         mask = {$urandom, $urandom} & {$urandom, $urandom};
         ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0;
         applyStimulus(n, mask, ab, 1'($urandom));
      end

      idleCycles(LAT + 3);
      @(negedge CLK);
      #1;
      testsRun++;
      if (ctlQ.size() != 0 || outQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d status and %0d beats pending, expected 0 and 0",
                  ctlQ.size(), outQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pipe_valid_sequencer.md
Name: pipe_valid_sequencer

Overview:
Sequences a fixed-latency, non-stallable PE datapath built from chains of 1-bit register stages. On a START command it issues NUM_BEATS valid beats into the pipeline, honouring a HOLD back-pressure input. It carries valid and last tags through an internal LATENCY-deep shadow pipeline that matches the datapath, and pulses DONE once the final beat has left. It sits between the layer controller and each PE column.

Parameters:
LATENCY, 3, datapath depth in register stages; must be ≥1.
CNT_W, 16, width of the beat count.

Ports:
CLK  input  1  clock; all logic on rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  start command; sampled only in IDLE.
NUM_BEATS  input  CNT_W  beats to issue; latched with START.
HOLD  input  1  suppresses issue this cycle; does not affect in-flight beats.
ISSUE_VALID  output  1  beat enters datapath this cycle.
ISSUE_LAST  output  1  qualifies ISSUE_VALID as the final beat.
OUT_VALID  output  1  datapath output valid this cycle.
OUT_LAST  output  1  qualifies OUT_VALID as the final beat.
BUSY  output  1  high in ISSUE, DRAIN and DONE.
DONE  output  1  one-cycle completion pulse.
BEATS_LEFT  output  CNT_W  beats not yet issued.

Behaviour:
Reset (RESET=1 at an edge) takes effect at the next cycle and has priority over all other inputs:
- state goes to IDLE;
- beat counter, BEATS_LEFT and every shadow-pipeline stage clear to 0;
- all outputs read 0 in the cycle after the reset edge.
- Reset mid-operation abandons the command. No DONE is produced and no stale OUT_VALID emerges.

States:
- IDLE
  - START=1 and NUM_BEATS≠0: latch count, go to ISSUE.
  - START=1 and NUM_BEATS=0: go straight to DONE.
  - START=0: stay.
- ISSUE
  - ISSUE_VALID = ~HOLD; this is combinational from registered state.
  - Each issued beat decrements the counter.
  - ISSUE_LAST = ISSUE_VALID and (counter==1).
  - On the last issued beat, go to DRAIN.
  - HOLD=1: no issue, counter unchanged, state unchanged, indefinitely.
- DRAIN
  - Wait until OUT_LAST=1, then go to DONE.
  - HOLD is ignored.
- DONE
  - DONE=1 for exactly one cycle, then go to IDLE.

START rules:
- START is ignored in ISSUE, DRAIN and DONE. It is not queued.
- A new START is accepted only in the cycle after DONE, when the state is IDLE.

Shadow pipeline:
- Stage 0 captures {ISSUE_VALID, ISSUE_LAST} each edge; stage k captures stage k-1.
- OUT_VALID and OUT_LAST come from stage LATENCY-1.
- A beat issued in cycle c appears on OUT_VALID in cycle c+LATENCY exactly.
- HOLD bubbles propagate as OUT_VALID=0 gaps.

Other outputs:
- BEATS_LEFT equals the counter value. It is 0 in IDLE, DRAIN and DONE.
- With NUM_BEATS=2^CNT_W-1 the counter must not wrap.
- DONE timing: DONE is asserted the cycle after the OUT_LAST cycle, so completion latency = issue-end + LATENCY + 1.

Test Plan:
1. LATENCY=3, START at cycle 0 with NUM_BEATS=4, HOLD=0 -> ISSUE_VALID cycles 1-4, ISSUE_LAST cycle 4, OUT_VALID cycles 4-7, OUT_LAST cycle 7, DONE cycle 8 only, BUSY cycles 1-8, BEATS_LEFT 4,3,2,1 in cycles 1-4.
2. Same command, HOLD=1 in cycles 2-3 -> ISSUE_VALID cycles 1,4,5,6; OUT_VALID cycles 4,7,8,9; OUT_LAST 9; DONE 10.
3. NUM_BEATS=0 at cycle 0 -> DONE=1 cycle 1, no ISSUE_VALID/OUT_VALID ever, BUSY only cycle 1, IDLE cycle 2.
4. START held high continuously with NUM_BEATS=2 -> second command accepted only in the IDLE cycle after DONE; no beats are lost or duplicated; DONE pulses once per command.
5. RESET=1 in cycle 3 of the scenario-1 command -> from cycle 4 all outputs 0, OUT_VALID stays 0 (no stale beats), no DONE; START in cycle 4 with RESET=0 is accepted.
6. LATENCY=1, NUM_BEATS=1 -> ISSUE_VALID+ISSUE_LAST cycle 1, OUT_VALID+OUT_LAST cycle 2, DONE cycle 3.
